// File: rtl/cp0_irq_unit.sv
// -----------------------------------------------------------------------------
// cp0_irq_unit
//
// Coprocessor-0 register file and interrupt unit for the 5-stage MIPS pipeline.
// Lives in the MEM stage: holds SR, Cause, EPC and PRId, synchronises the
// hardware interrupt lines, arbitrates them against synchronous exceptions and
// produces the take-exception strobe together with the handler address.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   rd_addr      CP0 read select (mfc0 rd field)
//   rd_data      combinational read data
//   wr_addr      CP0 write select (mtc0 rd field)
//   wr_data      write data
//   wr_en        mtc0 commit
//   eret         eret commit
//   exc_code     pending synchronous ExcCode (0 = none)
//   exc_pc       PC of the attributed instruction
//   exc_bd       attributed instruction sits in a branch delay slot
//   int_ok       a valid attributable instruction is present this cycle
//   hwint        raw asynchronous interrupt lines
//   epc          current EPC (eret forwarding)
//   goto_handler exception/interrupt taken this cycle
//   handler_pc   handler address, valid while goto_handler=1
// -----------------------------------------------------------------------------
module cp0_irq_unit #(
    parameter int unsigned NUM_HWINT   = 6,
    parameter logic [7:0]  EDGE_MASK   = 8'h00,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] EXC_BASE    = 32'h0000_4180,
    parameter bit          VECTORED    = 1'b0,
    parameter int unsigned VEC_SPACING = 32,
    parameter logic [31:0] PRID        = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rd_addr,
    output logic [31:0]          rd_data,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 wr_en,
    input  logic                 eret,
    input  logic [4:0]           exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic                 int_ok,
    input  logic [NUM_HWINT-1:0] hwint,
    output logic [31:0]          epc,
    output logic                 goto_handler,
    output logic [31:0]          handler_pc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // Synchroniser chain and edge history
    logic [NUM_HWINT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_HWINT-1:0] hist_q;
    logic [NUM_HWINT-1:0] sticky_q, sticky_d;

    // Architectural state
    logic [NUM_HWINT-1:0] im_q, im_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic [4:0]           code_q, code_d;
    logic [31:0]          epc_q, epc_d;

    // Derived signals
    logic [NUM_HWINT-1:0] synced, edge_det, ip, pend;
    logic                 has_exc, irq_pend, take;
    logic [2:0]           win_idx;
    logic [31:0]          pc_adj;
    logic                 cause_wr;
    logic [1:0]           unused_pc_bits;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign edge_det = synced & ~hist_q;

    // Edge lines expose the freshly detected edge in the same cycle so that the
    // IP bit sees the same SYNC_STAGES latency as a level line.
    always_comb begin
        ip = '0;
        for (int unsigned i = 0; i < NUM_HWINT; i++) begin
            ip[i] = EDGE_MASK[i] ? (sticky_q[i] | edge_det[i]) : synced[i];
        end
    end

    assign pend     = ip & im_q;
    assign has_exc  = |exc_code;
    assign irq_pend = ie_q & ~exl_q & int_ok & (|pend);
    assign take     = reset & (has_exc | irq_pend);

    assign goto_handler = take;
    assign epc          = epc_q;

    // Ascending scan: the last hit is the highest pending line.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_HWINT; i++) begin
            if (pend[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    always_comb begin
        handler_pc = EXC_BASE;
        if (VECTORED && !has_exc) begin
            handler_pc = EXC_BASE + 32'(VEC_SPACING) * (32'(win_idx) + 32'd1);
        end
    end

    assign pc_adj         = exc_bd ? (exc_pc - 32'd4) : exc_pc;
    assign unused_pc_bits = pc_adj[1:0];
    assign cause_wr       = ~take & wr_en & (wr_addr == ADDR_CAUSE);

    // Next state
    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;

        // A clearing write loses against a same-cycle edge.
        sticky_d = sticky_q | edge_det;
        for (int unsigned i = 0; i < NUM_HWINT; i++) begin
            if (cause_wr && !wr_data[8+i]) begin
                sticky_d[i] = edge_det[i];
            end
            if (!EDGE_MASK[i]) begin
                sticky_d[i] = 1'b0;
            end
        end

        if (take) begin
            exl_d  = 1'b1;
            bd_d   = exc_bd;
            epc_d  = {pc_adj[31:2], 2'b00};
            code_d = exc_code;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    ADDR_SR: begin
                        im_d  = wr_data[8 +: NUM_HWINT];
                        exl_d = wr_data[1];
                        ie_d  = wr_data[0];
                    end
                    ADDR_EPC: epc_d = {wr_data[31:2], 2'b00};
                    default: ;
                endcase
            end
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q   <= '0;
            sticky_q <= '0;
            im_q     <= '0;
            exl_q    <= 1'b0;
            ie_q     <= 1'b0;
            bd_q     <= 1'b0;
            code_q   <= '0;
            epc_q    <= '0;
        end else begin
            sync_q[0] <= hwint;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q   <= synced;
            sticky_q <= sticky_d;
            im_q     <= im_d;
            exl_q    <= exl_d;
            ie_q     <= ie_d;
            bd_q     <= bd_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
        end
    end

    // Register read mux
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_SR:    rd_data = {16'h0000, 8'(im_q), 6'b000000, exl_q, ie_q};
            ADDR_CAUSE: rd_data = {bd_q, 15'h0000, 8'(ip), 1'b0, code_q, 2'b00};
            ADDR_EPC:   rd_data = epc_q;
            ADDR_PRID:  rd_data = PRID;
            default:    rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_unit.sv
module tb_cp0_irq_unit;

    localparam int unsigned P_NUM  = 6;
    localparam logic [7:0]  P_EDGE = 8'h21;
    localparam int          P_S    = 2;
    localparam logic [31:0] P_BASE = 32'h0000_4180;
    localparam bit          P_VEC  = 1'b1;
    localparam int unsigned P_SP   = 32;
    localparam logic [31:0] P_PRID = 32'h0001_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr, wr_addr, exc_code;
    logic [31:0] rd_data, wr_data, exc_pc, epc, handler_pc;
    logic        wr_en, eret, exc_bd, int_ok, goto_handler;
    logic [5:0]  hwint;

    cp0_irq_unit #(
        .NUM_HWINT  (P_NUM),
        .EDGE_MASK  (P_EDGE),
        .SYNC_STAGES(P_S),
        .EXC_BASE   (P_BASE),
        .VECTORED   (P_VEC),
        .VEC_SPACING(P_SP),
        .PRID       (P_PRID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .eret        (eret),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .exc_bd      (exc_bd),
        .int_ok      (int_ok),
        .hwint       (hwint),
        .epc         (epc),
        .goto_handler(goto_handler),
        .handler_pc  (handler_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        go;
        logic [31:0] hpc;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    // Next-cycle stimulus
    logic        n_rst, n_we, n_er, n_bd, n_iok;
    logic [4:0]  n_ra, n_wa, n_ec;
    logic [31:0] n_wd, n_pc;
    logic [5:0]  n_hw;

    // Reference model state: what software sees in SR/Cause/EPC
    logic [5:0]  m_im, m_sticky;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic [5:0]  applied[$];   // hwint values seen by the synchroniser, oldest first
    logic [7:0]  edge_mask = P_EDGE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("goto_handler", {31'b0, goto_handler}, {31'b0, e.go});
            check("rd_data", rd_data, e.rd);
            check("epc", epc, e.epc);
            if (e.go) check("handler_pc", handler_pc, e.hpc);
        end
    end

    task automatic tick();
        exp_t        e;
        logic [5:0]  syn, prv, edg, ip, pend;
        logic [31:0] sr_w, ca_w, pcv;
        logic        irq;
        int          n, k;

        reset = n_rst; rd_addr = n_ra; wr_addr = n_wa; wr_data = n_wd; wr_en = n_we;
        eret = n_er; exc_code = n_ec; exc_pc = n_pc; exc_bd = n_bd; int_ok = n_iok; hwint = n_hw;

        if (!n_rst) begin
            m_im = 0; m_sticky = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = 0; m_epc = 0;
            applied.delete();
            e.go = 1'b0; e.hpc = '0; e.epc = '0;
            e.rd = (n_ra == 5'd15) ? P_PRID : 32'h0;
        end else begin
            n   = applied.size();
            syn = (n >= P_S)     ? applied[n-P_S]   : 6'h00;
            prv = (n >= P_S + 1) ? applied[n-P_S-1] : 6'h00;
            edg = syn & ~prv;
            for (int i = 0; i < 6; i++) ip[i] = edge_mask[i] ? (m_sticky[i] | edg[i]) : syn[i];
            pend = ip & m_im;
            irq  = m_ie && !m_exl && n_iok && (pend != 0);
            sr_w = {16'h0, 2'b00, m_im, 6'h00, m_exl, m_ie};
            ca_w = {m_bd, 15'h0, 2'b00, ip, 1'b0, m_code, 2'b00};

            e.go  = (n_ec != 0) || irq;
            e.epc = m_epc;
            k = -1;
            for (int i = 5; i >= 0; i--) if (pend[i]) begin k = i; break; end
            if (n_ec != 0 || !P_VEC) e.hpc = P_BASE;
            else                     e.hpc = P_BASE + P_SP * (k + 1);
            case (n_ra)
                5'd12:   e.rd = sr_w;
                5'd13:   e.rd = ca_w;
                5'd14:   e.rd = m_epc;
                5'd15:   e.rd = P_PRID;
                default: e.rd = 32'h0;
            endcase

            // state after this edge
            for (int i = 0; i < 6; i++) begin
                if (!edge_mask[i]) m_sticky[i] = 1'b0;
                else if (!e.go && n_we && n_wa == 5'd13 && !n_wd[8+i]) m_sticky[i] = edg[i];
                else m_sticky[i] = m_sticky[i] | edg[i];
            end
            if (e.go) begin
                m_exl = 1'b1; m_bd = n_bd; m_code = n_ec;
                pcv = n_bd ? n_pc - 32'd4 : n_pc;
                m_epc = pcv & 32'hFFFF_FFFC;
            end else begin
                if (n_we && n_wa == 5'd12) begin
                    m_im = n_wd[13:8]; m_exl = n_wd[1]; m_ie = n_wd[0];
                end
                if (n_we && n_wa == 5'd14) m_epc = n_wd & 32'hFFFF_FFFC;
                if (n_er) m_exl = 1'b0;
            end
            applied.push_back(n_hw);
            if (applied.size() > 8) void'(applied.pop_front());
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        n_we = 1'b1; n_wa = a; n_wd = d;
        tick();
        n_we = 1'b0;
    endtask

    initial begin
        n_rst = 0; n_ra = 5'd12; n_wa = 0; n_wd = 0; n_we = 0; n_er = 0; n_ec = 0;
        n_pc = 0; n_bd = 0; n_iok = 0; n_hw = 0;
        reset = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; wr_en = 0; eret = 0;
        exc_code = 0; exc_pc = 0; exc_bd = 0; int_ok = 0; hwint = 0;
        @(posedge clk); #1;

        // reset values, then after release
        for (int r = 12; r < 16; r++) begin n_ra = 5'(r); tick(); end
        n_rst = 1;
        for (int r = 12; r < 16; r++) begin n_ra = 5'(r); tick(); end

        // all lines high, SR=0: IP fills, nothing taken
        n_hw = 6'h3F; n_iok = 1; n_ra = 5'd13;
        repeat (4) tick();
        n_hw = 6'h00; repeat (3) tick();
        wr(5'd13, 32'h0); tick();

        // level line 2 interrupt
        wr(5'd12, 32'h0000_0401);
        n_pc = 32'h3010; n_hw = 6'h04; n_ra = 5'd14;
        repeat (4) tick();
        n_ra = 5'd13; tick();
        n_ra = 5'd12; tick();
        n_hw = 6'h00; repeat (3) tick();
        n_er = 1; tick(); n_er = 0; tick();

        // vectored: lines 1 and 4 pending, line 4 wins
        wr(5'd12, 32'h0000_1201);
        n_hw = 6'h12; repeat (4) tick();
        n_hw = 6'h00; repeat (3) tick();
        n_er = 1; tick(); n_er = 0;

        // edge line 0: sticky, cleared by write, edge beats same-cycle clear
        wr(5'd12, 32'h0); n_ra = 5'd13;
        n_hw = 6'h01; tick(); n_hw = 6'h00; repeat (4) tick();
        wr(5'd13, 32'h0); tick();
        n_hw = 6'h01; tick(); n_hw = 6'h00; tick();
        wr(5'd13, 32'h0); repeat (2) tick();
        wr(5'd13, 32'h0);

        // exception beats pending interrupt; same-cycle mtc0 dropped
        wr(5'd12, 32'h0000_0401);
        n_hw = 6'h04; n_iok = 0; repeat (3) tick();
        n_iok = 1; n_ec = 5'd12; n_bd = 1; n_pc = 32'h3008;
        n_we = 1; n_wa = 5'd14; n_wd = 32'hDEAD_BEEF; n_ra = 5'd14;
        tick();
        n_we = 0; n_ec = 0; n_bd = 0;
        tick(); n_ra = 5'd13; tick(); n_ra = 5'd12; tick();

        // asynchronous reset mid-service
        n_hw = 6'h00; n_rst = 0; n_ra = 5'd14; tick();
        n_ra = 5'd12; tick(); n_ra = 5'd13; tick();
        n_rst = 1; tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            n_rst = ($urandom_range(0, 499) != 0);
            r = $urandom_range(0, 9);
            n_ra = (r < 8) ? 5'(12 + r % 4) : 5'($urandom);
            n_we = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            n_wa = (r < 9) ? 5'(12 + r % 3) : 5'($urandom);
            n_wd = $urandom;
            if (n_wa == 5'd12) begin
                n_wd[1] = ($urandom_range(0, 3) == 0);
                n_wd[0] = ($urandom_range(0, 3) != 0);
            end
            n_er  = !n_we && ($urandom_range(0, 7) == 0);
            n_ec  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            n_pc  = $urandom;
            n_bd  = 1'($urandom);
            n_iok = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) n_hw = 6'($urandom);
            tick();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
